// File: rtl/shape_pkg.sv
// Shared constants and types for the shape plot scheduler: screen size,
// shape table (size and colour per shape id) and the scheduler FSM states.
package shape_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned COL_W = 3;
  localparam int unsigned DIM_W = 4;
  localparam int unsigned SX_W  = X_W + 1;
  localparam int unsigned SY_W  = Y_W + 1;

  localparam int unsigned SCR_W = 160;
  localparam int unsigned SCR_H = 120;

  localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COL_W-1:0] COL_RED   = 3'b100;
  localparam logic [COL_W-1:0] COL_GREEN = 3'b010;
  localparam logic [COL_W-1:0] COL_CYAN  = 3'b011;
  localparam logic [COL_W-1:0] COL_WHITE = 3'b111;

  // Shape table indexed by shape id (= requester id)
  localparam logic [DIM_W-1:0] SHAPE_W [N_REQ] = '{4'd7, 4'd8, 4'd7, 4'd10};
  localparam logic [DIM_W-1:0] SHAPE_H [N_REQ] = '{4'd12, 4'd8, 4'd10, 4'd6};
  localparam logic [COL_W-1:0] SHAPE_COL [N_REQ] = '{COL_RED, COL_GREEN, COL_CYAN, COL_WHITE};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ERASE  = 3'd2,
    DRAW   = 3'd3,
    FINISH = 3'd4
  } sched_state_t;

endpackage

// File: rtl/shape_plot_sched_if.sv
// Requester-side and VGA-adapter-side signals of the shape plot scheduler.
// master = game logic / environment, slave = scheduler.
interface shape_plot_sched_if;
  import shape_pkg::*;

  logic [N_REQ-1:0]     req;
  logic [N_REQ*X_W-1:0] x_in;
  logic [N_REQ*Y_W-1:0] y_in;
  logic [N_REQ-1:0]     grant;
  logic [N_REQ-1:0]     done;
  logic                 busy;
  logic [X_W-1:0]       vga_x;
  logic [Y_W-1:0]       vga_y;
  logic [COL_W-1:0]     vga_color;
  logic                 vga_plot;

  modport master (
    output req, x_in, y_in,
    input  grant, done, busy, vga_x, vga_y, vga_color, vga_plot
  );

  modport slave (
    input  req, x_in, y_in,
    output grant, done, busy, vga_x, vga_y, vga_color, vga_plot
  );

endinterface

// File: rtl/shape_raster.sv
// Row-major pixel walker for one shape rectangle: px runs fastest, wraps to
// zero after the last pixel so an erase pass flows straight into a draw pass.
module shape_raster
  import shape_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             step,
  input  logic [ID_W-1:0]  shape,
  input  logic [X_W-1:0]   base_x,
  input  logic [Y_W-1:0]   base_y,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             clip,
  output logic             last
);

  logic [DIM_W-1:0] px;
  logic [DIM_W-1:0] py;
  logic [DIM_W-1:0] w_m1;
  logic [DIM_W-1:0] h_m1;
  logic             end_row;
  logic [SX_W-1:0]  sum_x;
  logic [SY_W-1:0]  sum_y;

  assign w_m1    = SHAPE_W[shape] - DIM_W'(1);
  assign h_m1    = SHAPE_H[shape] - DIM_W'(1);
  assign end_row = (px == w_m1);
  assign last    = end_row && (py == h_m1);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      px <= '0;
      py <= '0;
    end else if (step) begin
      if (end_row) begin
        px <= '0;
        py <= (py == h_m1) ? '0 : py + DIM_W'(1);
      end else begin
        px <= px + DIM_W'(1);
      end
    end
  end

  // Sums are one bit wider than the screen coords so off-screen pixels never wrap back on
  assign sum_x = {1'b0, base_x} + SX_W'(px);
  assign sum_y = {1'b0, base_y} + SY_W'(py);
  assign clip  = (sum_x >= SX_W'(SCR_W)) || (sum_y >= SY_W'(SCR_H));
  assign pix_x = sum_x[X_W-1:0];
  assign pix_y = sum_y[Y_W-1:0];

endmodule

// File: rtl/shape_plot_sched.sv
// Round-robin scheduler of four shape requesters onto the VGA plot port.
// Optional macro ERASE_EN: repaint each requester's previous rectangle black before redrawing.
module shape_plot_sched
  import shape_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               resetn,
  shape_plot_sched_if.slave  bus
);

  sched_state_t state, state_nxt;

  logic [ID_W-1:0]  rr_ptr, rr_nxt;
  logic [ID_W-1:0]  gid, gid_nxt;
  logic [X_W-1:0]   lat_x, lat_x_nxt;
  logic [Y_W-1:0]   lat_y, lat_y_nxt;
  logic [N_REQ-1:0] grant_r, grant_nxt;
  logic [N_REQ-1:0] done_r, done_nxt;
  logic             busy_r, busy_nxt;
  logic [X_W-1:0]   vga_x_r, vga_x_nxt;
  logic [Y_W-1:0]   vga_y_r, vga_y_nxt;
  logic [COL_W-1:0] vga_color_r, vga_color_nxt;
  logic             vga_plot_r, vga_plot_nxt;
  logic             vga_last, vga_last_nxt;

  logic             ras_clear, ras_step, emit;
  logic             use_prev;
  logic [X_W-1:0]   base_x, pix_x;
  logic [Y_W-1:0]   base_y, pix_y;
  logic             pix_clip, pix_last;
  logic [ID_W-1:0]  win;
  logic             win_found;

`ifdef ERASE_EN
  logic [X_W-1:0]   prev_x [N_REQ];
  logic [Y_W-1:0]   prev_y [N_REQ];
  logic [N_REQ-1:0] prev_valid;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      prev_valid <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        prev_x[i] <= '0;
        prev_y[i] <= '0;
      end
    end else if (state == FINISH) begin
      prev_x[gid]     <= lat_x;
      prev_y[gid]     <= lat_y;
      prev_valid[gid] <= 1'b1;
    end
  end

  // Erase coordinates are used for the LOAD pixel and every ERASE pixel but the last
  always_comb begin
    use_prev = 1'b0;
    case (state)
      LOAD:    use_prev = prev_valid[gid];
      ERASE:   use_prev = !vga_last;
      default: use_prev = 1'b0;
    endcase
  end

  always_comb begin
    base_x = use_prev ? prev_x[gid] : lat_x;
    base_y = use_prev ? prev_y[gid] : lat_y;
  end
`else
  assign use_prev = 1'b0;
  assign base_x   = lat_x;
  assign base_y   = lat_y;
`endif

  // First requesting id at or after rr_ptr, wrapping
  always_comb begin
    win       = rr_ptr;
    win_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && bus.req[rr_ptr + ID_W'(i)]) begin
        win       = rr_ptr + ID_W'(i);
        win_found = 1'b1;
      end
    end
  end

  shape_raster u_raster (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .clear  (ras_clear),
    .step   (ras_step),
    .shape  (gid),
    .base_x (base_x),
    .base_y (base_y),
    .pix_x  (pix_x),
    .pix_y  (pix_y),
    .clip   (pix_clip),
    .last   (pix_last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // The VGA registers are loaded one cycle ahead: the pixel emitted in LOAD is on the port in the first ERASE/DRAW cycle
  always_comb begin
    state_nxt     = state;
    rr_nxt        = rr_ptr;
    gid_nxt       = gid;
    lat_x_nxt     = lat_x;
    lat_y_nxt     = lat_y;
    grant_nxt     = grant_r;
    done_nxt      = '0;
    ras_clear     = 1'b0;
    ras_step      = 1'b0;
    emit          = 1'b0;
    vga_x_nxt     = vga_x_r;
    vga_y_nxt     = vga_y_r;
    vga_color_nxt = vga_color_r;
    vga_plot_nxt  = 1'b0;
    vga_last_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = LOAD;
          gid_nxt   = win;
          lat_x_nxt = bus.x_in[X_W*win +: X_W];
          lat_y_nxt = bus.y_in[Y_W*win +: Y_W];
          grant_nxt = N_REQ'(1) << win;
          ras_clear = 1'b1;
        end
      end
      LOAD: begin
        emit      = 1'b1;
        state_nxt = use_prev ? ERASE : DRAW;
      end
`ifdef ERASE_EN
      ERASE: begin
        emit = 1'b1;
        if (vga_last) state_nxt = DRAW;
      end
`endif
      DRAW: begin
        if (vga_last) begin
          state_nxt = FINISH;
          done_nxt  = grant_r;
        end else begin
          emit = 1'b1;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        rr_nxt    = gid + ID_W'(1);
      end
      default: state_nxt = IDLE;
    endcase

    if (emit) begin
      ras_step      = 1'b1;
      vga_x_nxt     = pix_x;
      vga_y_nxt     = pix_y;
      vga_color_nxt = use_prev ? COL_BLACK : SHAPE_COL[gid];
      vga_plot_nxt  = !pix_clip;
      vga_last_nxt  = pix_last;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      rr_ptr      <= '0;
      gid         <= '0;
      lat_x       <= '0;
      lat_y       <= '0;
      grant_r     <= '0;
      done_r      <= '0;
      busy_r      <= 1'b0;
      vga_x_r     <= '0;
      vga_y_r     <= '0;
      vga_color_r <= '0;
      vga_plot_r  <= 1'b0;
      vga_last    <= 1'b0;
    end else begin
      rr_ptr      <= rr_nxt;
      gid         <= gid_nxt;
      lat_x       <= lat_x_nxt;
      lat_y       <= lat_y_nxt;
      grant_r     <= grant_nxt;
      done_r      <= done_nxt;
      busy_r      <= busy_nxt;
      vga_x_r     <= vga_x_nxt;
      vga_y_r     <= vga_y_nxt;
      vga_color_r <= vga_color_nxt;
      vga_plot_r  <= vga_plot_nxt;
      vga_last    <= vga_last_nxt;
    end
  end

  assign bus.grant     = grant_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.vga_x     = vga_x_r;
  assign bus.vga_y     = vga_y_r;
  assign bus.vga_color = vga_color_r;
  assign bus.vga_plot  = vga_plot_r;

endmodule

// File: tb/tb_shape_plot_sched.sv
// Directed bench for shape_plot_sched: job vectors from a table plus
// hand-written arbitration, erase/redraw and mid-job reset sequences.
`timescale 1ns/1ps
module tb_shape_plot_sched;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  shape_plot_sched_if bus ();

  shape_plot_sched dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] req;
    int id; int xi; int yi;
    int gnt; int np; int fx; int fy; int lx; int ly; int col; int dc;
  } vec_t;

  typedef struct {
    int np; int nb; int fx; int fy; int lx; int ly;
    int bfx; int bfy; int blx; int bly;
    int col; int coldiff; int oob; int fpc;
    int gfirst; int gnt; int gcnt; int bcnt; int dcyc; int dval; int got;
  } res_t;

  vec_t vecs [4];
  res_t res;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] place_x(input int id, input int v);
    logic [31:0] t;
    t = {4{8'hC8}};
    t[8*id +: 8] = 8'(v);
    return t;
  endfunction

  function automatic logic [27:0] place_y(input int id, input int v);
    logic [27:0] t;
    t = {4{7'h55}};
    t[7*id +: 7] = 7'(v);
    return t;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    resetn  = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Cycle 0 = the IDLE cycle in which req is first presented; returns after the done cycle
  task automatic run_job(input logic [3:0] r, input logic [31:0] xv, input logic [27:0] yv,
                         input bit drop);
    int x, y;
    res = '{default: 0};
    @(posedge clk); #1;
    bus.req  = r;
    bus.x_in = xv;
    bus.y_in = yv;
    for (int k = 0; k < 400 && res.got == 0; k++) begin
      @(negedge clk);
      x = int'(bus.vga_x);
      y = int'(bus.vga_y);
      if (bus.vga_plot) begin
        if (bus.vga_color == 3'b000) begin
          if (res.nb == 0) begin res.bfx = x; res.bfy = y; end
          res.blx = x; res.bly = y; res.nb++;
        end else begin
          if (res.np == 0) begin
            res.fx = x; res.fy = y; res.col = int'(bus.vga_color); res.fpc = k;
          end else if (int'(bus.vga_color) != res.col) begin
            res.coldiff++;
          end
          res.lx = x; res.ly = y; res.np++;
        end
        if (x >= 160 || y >= 120) res.oob++;
      end
      if (bus.grant != 4'b0000) begin
        if (res.gcnt == 0) begin res.gfirst = k; res.gnt = int'(bus.grant); end
        res.gcnt++;
      end
      if (bus.busy) res.bcnt++;
      if (bus.done != 4'b0000) begin
        res.got = 1; res.dcyc = k; res.dval = int'(bus.done);
      end
      if (drop && k == 0) begin
        @(posedge clk); #1;
        bus.req  = '0;
        bus.x_in = ~xv;
        bus.y_in = ~yv;
      end
    end
    chk("job_done_seen", res.got, 1);
  endtask

  initial begin
    int bad;
    int d_cnt;

    vecs[0] = '{4'b0001, 0, 10,  20,  1, 84, 10,  20,  16,  31,  4, 86};
    vecs[1] = '{4'b0010, 1, 100, 60,  2, 64, 100, 60,  107, 67,  2, 66};
    vecs[2] = '{4'b0100, 2, 0,   0,   4, 70, 0,   0,   6,   9,   3, 72};
    vecs[3] = '{4'b1000, 3, 155, 118, 8, 10, 155, 118, 159, 119, 7, 62};

    // Reset state and idle hold
    resetn   = 1'b0;
    bus.req  = '0;
    bus.x_in = '0;
    bus.y_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_done",  int'(bus.done), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_plot",  int'(bus.vga_plot), 0);
    chk("rst_vga_x", int'(bus.vga_x), 0);
    chk("rst_vga_y", int'(bus.vga_y), 0);
    chk("rst_color", int'(bus.vga_color), 0);
    @(posedge clk); #1 resetn = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.grant != 4'b0000 || bus.vga_plot) bad++;
    end
    chk("idle_hold", bad, 0);

    // Single-requester job vectors; req dropped and coords scrambled after sampling
    for (int i = 0; i < 4; i++) begin
      run_job(vecs[i].req, place_x(vecs[i].id, vecs[i].xi), place_y(vecs[i].id, vecs[i].yi), 1'b1);
      chk($sformatf("v%0d_grant", i),      res.gnt, vecs[i].gnt);
      chk($sformatf("v%0d_done_val", i),   res.dval, vecs[i].gnt);
      chk($sformatf("v%0d_done_cyc", i),   res.dcyc, vecs[i].dc);
      chk($sformatf("v%0d_nplots", i),     res.np, vecs[i].np);
      chk($sformatf("v%0d_first_x", i),    res.fx, vecs[i].fx);
      chk($sformatf("v%0d_first_y", i),    res.fy, vecs[i].fy);
      chk($sformatf("v%0d_last_x", i),     res.lx, vecs[i].lx);
      chk($sformatf("v%0d_last_y", i),     res.ly, vecs[i].ly);
      chk($sformatf("v%0d_color", i),      res.col, vecs[i].col);
      chk($sformatf("v%0d_color_diff", i), res.coldiff, 0);
      chk($sformatf("v%0d_offscreen", i),  res.oob, 0);
      chk($sformatf("v%0d_black", i),      res.nb, 0);
      chk($sformatf("v%0d_first_cyc", i),  res.fpc, 2);
      chk($sformatf("v%0d_grant_first", i), res.gfirst, 1);
      chk($sformatf("v%0d_grant_cycles", i), res.gcnt, vecs[i].dc);
      chk($sformatf("v%0d_busy_cycles", i),  res.bcnt, vecs[i].dc);
    end

    // Round robin with all requests held, then a wrap from rr_ptr
    for (int j = 0; j < 4; j++) begin
      run_job(4'b1111, {4{8'd20}}, {4{7'd20}}, 1'b0);
      chk($sformatf("rr%0d_grant", j), res.gnt, 1 << j);
      chk($sformatf("rr%0d_done", j),  res.dval, 1 << j);
    end
    run_job(4'b1001, {4{8'd30}}, {4{7'd30}}, 1'b0);
    chk("rr_1001_a", res.gnt, 1);
    run_job(4'b1001, {4{8'd30}}, {4{7'd30}}, 1'b0);
    chk("rr_1001_b", res.gnt, 8);
    bus.req = '0;

    // Same requester twice: erase of the old rectangle only when ERASE_EN is built
    do_reset();
    run_job(4'b0010, place_x(1, 0), place_y(1, 0), 1'b1);
    chk("er_job1_done", res.dcyc, 66);
    chk("er_job1_black", res.nb, 0);
    run_job(4'b0010, place_x(1, 50), place_y(1, 50), 1'b1);
    chk("er_job2_nplots", res.np, 64);
    chk("er_job2_first_x", res.fx, 50);
    chk("er_job2_first_y", res.fy, 50);
    chk("er_job2_last_x", res.lx, 57);
    chk("er_job2_last_y", res.ly, 57);
    chk("er_job2_color", res.col, 2);
`ifdef ERASE_EN
    chk("er_job2_black", res.nb, 64);
    chk("er_job2_bfirst_x", res.bfx, 0);
    chk("er_job2_bfirst_y", res.bfy, 0);
    chk("er_job2_blast_x", res.blx, 7);
    chk("er_job2_blast_y", res.bly, 7);
    chk("er_job2_draw_cyc", res.fpc, 66);
    chk("er_job2_done", res.dcyc, 130);
`else
    chk("er_job2_black", res.nb, 0);
    chk("er_job2_draw_cyc", res.fpc, 2);
    chk("er_job2_done", res.dcyc, 66);
`endif

    // Reset in the middle of a DRAW aborts the job
    @(posedge clk); #1;
    bus.req  = 4'b0001;
    bus.x_in = place_x(0, 10);
    bus.y_in = place_y(0, 20);
    d_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done != 4'b0000) d_cnt++;
    end
    chk("mid_plot_active", int'(bus.vga_plot), 1);
    @(posedge clk); #1;
    resetn  = 1'b0;
    bus.req = '0;
    @(negedge clk);
    if (bus.done != 4'b0000) d_cnt++;
    @(negedge clk);
    chk("mid_rst_plot",  int'(bus.vga_plot), 0);
    chk("mid_rst_busy",  int'(bus.busy), 0);
    chk("mid_rst_grant", int'(bus.grant), 0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.done != 4'b0000 || bus.vga_plot) d_cnt++;
    end
    chk("mid_rst_no_done", d_cnt, 0);
    run_job(4'b0001, place_x(0, 10), place_y(0, 20), 1'b1);
    chk("post_rst_black", res.nb, 0);
    chk("post_rst_nplots", res.np, 84);
    chk("post_rst_done", res.dcyc, 86);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
